// File: rtl/ex_stage_md.sv
// Execute stage of the mips_16 pipeline. Performs single-cycle ALU operations and
// hosts an iterative unsigned multiply/divide unit with a HI register. Emits the
// 38-bit ex->mem pipeline register and stalls upstream while MUL/DIVU iterates.
module ex_stage_md #(
  parameter int DATA_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [57:0] pipeline_reg_in,
  output logic [37:0] pipeline_reg_out,
  output logic [2:0]  ex_op_dest,
  output logic        ex_stall
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [3:0] {
    CMD_NOP  = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_AND  = 4'd3,
    CMD_OR   = 4'd4,
    CMD_XOR  = 4'd5,
    CMD_SLL  = 4'd6,
    CMD_SRL  = 4'd7,
    CMD_SRA  = 4'd8,
    CMD_MUL  = 4'd9,
    CMD_DIVU = 4'd10,
    CMD_MFHI = 4'd11
  } alu_cmd_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Decoded fields of the ID->EX register.
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [21:0]       pass_through;
  logic [3:0]        shamt;
  logic              is_md;

  assign alu_cmd      = pipeline_reg_in[57:54];
  assign src1         = pipeline_reg_in[53:38];
  assign src2         = pipeline_reg_in[37:22];
  assign pass_through = pipeline_reg_in[21:0];
  assign shamt        = src2[3:0];
  assign is_md        = (alu_cmd == CMD_MUL) || (alu_cmd == CMD_DIVU);

  // Destination register is forwarded to the hazard unit unconditionally.
  assign ex_op_dest = pipeline_reg_in[3:1];

  // Control and architectural state.
  state_e            state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] hi_reg;

  // Iterative datapath: acc_hi holds partial product / remainder, acc_lo holds
  // multiplier / dividend-shifting-into-quotient, opnd_b the fixed operand.
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic [DATA_W-1:0] opnd_b;
  logic              op_div;

  // Stall is asserted the moment a MUL/DIVU is seen in IDLE and throughout BUSY.
  assign ex_stall = !rst && (((state == S_IDLE) && is_md) || (state == S_BUSY));

  // Single-cycle ALU result.
  logic [DATA_W-1:0] alu_result;

  // Combinational ALU for all one-cycle commands.
  always_comb begin
    // NOTE: default assignment first so every path drives alu_result; no latch.
    alu_result = '0;
    unique case (alu_cmd)
      CMD_ADD:  alu_result = src1 + src2;
      CMD_SUB:  alu_result = src1 - src2;
      CMD_AND:  alu_result = src1 & src2;
      CMD_OR:   alu_result = src1 | src2;
      CMD_XOR:  alu_result = src1 ^ src2;
      CMD_SLL:  alu_result = src1 << shamt;
      CMD_SRL:  alu_result = src1 >> shamt;
      CMD_SRA:  alu_result = DATA_W'($signed(src1) >>> shamt);
      CMD_MFHI: alu_result = hi_reg;
      default:  alu_result = '0;
    endcase
  end

  // One shift-add multiply step and one restoring divide step.
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_rem_shift;
  logic [DATA_W:0]   div_diff;

  // Next-iteration arithmetic shared by both long operations.
  always_comb begin
    mul_sum       = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    div_rem_shift = {acc_hi, acc_lo[DATA_W-1]};
    div_diff      = div_rem_shift - {1'b0, opnd_b};
  end

  // Sequencer FSM with registered pipeline output and HI register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state            <= S_IDLE;
      count            <= '0;
      hi_reg           <= '0;
      pipeline_reg_out <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (is_md) begin
            pipeline_reg_out <= '0;
            count            <= '0;
            state            <= S_BUSY;
          end else begin
            pipeline_reg_out <= {alu_result, pass_through};
          end
        end
        S_BUSY: begin
          pipeline_reg_out <= '0;
          count            <= count + CNT_W'(1);
          if (count == CNT_W'(DATA_W - 1)) state <= S_DONE;
        end
        S_DONE: begin
          pipeline_reg_out <= {acc_lo, pass_through};
          hi_reg           <= acc_hi;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand latch at issue and one multiply/divide iteration per BUSY cycle.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these registers are always loaded at issue before
    // being read, and an aborted operation is simply reloaded on re-issue.
    if ((state == S_IDLE) && is_md) begin
      acc_hi <= '0;
      acc_lo <= src1;
      opnd_b <= src2;
      op_div <= (alu_cmd == CMD_DIVU);
    end else if (state == S_BUSY) begin
      if (op_div) begin
        // A zero divisor always "fits", giving quotient all-ones and the
        // dividend as remainder without special casing.
        if (!div_diff[DATA_W]) begin
          acc_hi <= div_diff[DATA_W-1:0];
          acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
        end else begin
          acc_hi <= div_rem_shift[DATA_W-1:0];
          acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
        end
      end else begin
        acc_hi <= mul_sum[DATA_W:1];
        acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Testbench for ex_stage_md: directed vectors with literal expectations plus a
// cycle-level reference model compared against the DUT on every falling edge.
`timescale 1ns/1ps
module tb_ex_stage_md;

  logic        clk = 1'b0;
  logic        rst;
  logic [57:0] in_reg;
  logic [37:0] dut_out;
  logic [2:0]  dut_dest;
  logic        dut_stall;

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  ex_stage_md #(.DATA_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .pipeline_reg_in  (in_reg),
    .pipeline_reg_out (dut_out),
    .ex_op_dest       (dut_dest),
    .ex_stall         (dut_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [37:0] got, input logic [37:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [57:0] pack(input logic [3:0] cmd, input logic [15:0] a,
                                       input logic [15:0] b, input logic [21:0] tail);
    return {cmd, a, b, tail};
  endfunction

  function automatic bit is_md(input logic [3:0] cmd);
    return (cmd == 4'd9) || (cmd == 4'd10);
  endfunction

  // Reference: one-cycle ALU from plain arithmetic.
  function automatic logic [15:0] ref_alu(input logic [3:0] cmd, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] hi);
    int sh;
    int sa;
    sh = int'(b[3:0]);
    sa = int'($signed(a));
    case (cmd)
      4'd1:    return 16'((int'(a) + int'(b)) % 65536);
      4'd2:    return 16'((int'(a) - int'(b) + 65536) % 65536);
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return 16'((int'(a) * (1 << sh)) % 65536);
      4'd7:    return 16'(int'(a) / (1 << sh));
      4'd8:    return 16'(sa >>> sh);
      4'd11:   return hi;
      default: return 16'h0000;
    endcase
  endfunction

  // Reference: long operation as {hi, result}.
  function automatic logic [31:0] ref_md(input bit div, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    if (!div) begin
      p = 32'(a) * 32'(b);
      return p;
    end
    if (b == 16'h0) return {a, 16'hFFFF};
    return {16'(a % b), 16'(a / b)};
  endfunction

  // Model state: cycles elapsed since a long op was accepted (0 = none pending).
  int          m_cnt = 0;
  logic [15:0] m_a, m_b, m_hi;
  bit          m_div;
  logic [37:0] m_out;
  logic [31:0] m_md;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_out <= '0;
      m_hi  <= '0;
    end else if (m_cnt == 0 && is_md(in_reg[57:54])) begin
      m_cnt <= 1;
      m_a   <= in_reg[53:38];
      m_b   <= in_reg[37:22];
      m_div <= (in_reg[57:54] == 4'd10);
      m_out <= '0;
    end else if (m_cnt >= 1 && m_cnt <= 16) begin
      m_cnt <= m_cnt + 1;
      m_out <= '0;
    end else if (m_cnt == 17) begin
      m_md   = ref_md(m_div, m_a, m_b);
      m_out <= {m_md[15:0], in_reg[21:0]};
      m_hi  <= m_md[31:16];
      m_cnt <= 0;
    end else begin
      m_out <= {ref_alu(in_reg[57:54], in_reg[53:38], in_reg[37:22], m_hi), in_reg[21:0]};
    end
    started <= 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      check("model_out", dut_out, m_out);
      check("model_stall", 38'(dut_stall),
            38'(!rst && ((m_cnt == 0 && is_md(in_reg[57:54])) || (m_cnt >= 1 && m_cnt <= 16))));
      check("model_dest", 38'(dut_dest), 38'(in_reg[3:1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b,
                       input logic [21:0] tail);
    in_reg = pack(cmd, a, b, tail);
    #1;
  endtask

  task automatic alu_op(input string name, input logic [3:0] cmd, input logic [15:0] a,
                        input logic [15:0] b, input logic [21:0] tail, input logic [15:0] exp);
    drive(cmd, a, b, tail);
    check({name, "_stall"}, 38'(dut_stall), 38'(0));
    step();
    check({name, "_res"}, 38'(dut_out[37:22]), 38'(exp));
    check({name, "_tail"}, 38'(dut_out[21:0]), 38'(tail));
  endtask

  task automatic md_op(input string name, input logic [3:0] cmd, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp);
    int n;
    drive(cmd, a, b, 22'h16);
    n = 0;
    while (dut_stall && n < 40) begin
      step();
      check({name, "_bubble"}, dut_out, 38'(0));
      n++;
    end
    check({name, "_stall_len"}, 38'(n), 38'(17));
    step();
    check({name, "_res"}, 38'(dut_out[37:22]), 38'(exp));
  endtask

  initial begin
    rst    = 1'b1;
    in_reg = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_out", dut_out, 38'(0));
    check("reset_stall", 38'(dut_stall), 38'(0));

    // Single-cycle operations.
    alu_op("add", 4'd1, 16'h1234, 16'h0001, 22'h16, 16'h1235);
    alu_op("sub", 4'd2, 16'h0000, 16'h0001, 22'h0ABCD, 16'hFFFF);
    alu_op("sra", 4'd8, 16'h8000, 16'h0004, 22'h3FFFFF, 16'hF800);
    alu_op("srl", 4'd7, 16'h8000, 16'h0004, 22'h00001, 16'h0800);
    alu_op("nop", 4'd0, 16'h5555, 16'h1111, 22'h00010, 16'h0000);
    alu_op("cmd13", 4'd13, 16'h5555, 16'h1111, 22'h00010, 16'h0000);

    // Multiply, then HI read.
    md_op("mul", 4'd9, 16'h0100, 16'h0100, 16'h0000);
    alu_op("mfhi_mul", 4'd11, 16'h0, 16'h0, 22'h16, 16'h0001);

    // Divide, including divide by zero.
    md_op("divu", 4'd10, 16'd100, 16'd7, 16'h000E);
    alu_op("mfhi_div", 4'd11, 16'h0, 16'h0, 22'h16, 16'h0002);
    md_op("divu0", 4'd10, 16'h1234, 16'h0000, 16'hFFFF);
    alu_op("mfhi_div0", 4'd11, 16'h0, 16'h0, 22'h16, 16'h1234);

    // Reset in the middle of a multiply.
    drive(4'd9, 16'hFFFF, 16'hFFFF, 22'h16);
    repeat (5) step();
    check("abort_busy_stall", 38'(dut_stall), 38'(1));
    rst    = 1'b1;
    in_reg = pack(4'd11, 16'h0, 16'h0, 22'h16);
    #1;
    check("abort_rst_stall", 38'(dut_stall), 38'(0));
    step();
    rst = 1'b0;
    #1;
    check("abort_out", dut_out, 38'(0));
    check("abort_stall", 38'(dut_stall), 38'(0));
    step();
    check("abort_mfhi", 38'(dut_out[37:22]), 38'(0));
    md_op("mul_ff", 4'd9, 16'hFFFF, 16'hFFFF, 16'h0001);
    alu_op("mfhi_ff", 4'd11, 16'h0, 16'h0, 22'h16, 16'hFFFE);

    // Back-to-back long operations.
    md_op("b2b_mul", 4'd9, 16'h0123, 16'h0456, 16'hEDC2);
    md_op("b2b_div", 4'd10, 16'hFFFF, 16'h0010, 16'h0FFF);
    alu_op("b2b_mfhi", 4'd11, 16'h0, 16'h0, 22'h16, 16'h000F);

    // Random single-cycle mix, checked by the model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      if (is_md(c)) c = 4'd11;
      drive(c, 16'($urandom), 16'($urandom), 22'($urandom));
      step();
    end

    drive(4'd0, 16'h0, 16'h0, 22'h0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
